dm_port_arbiter: RTL

- Shares the single-port, synchronous-read data memory (read and write on the active edge, 1-cycle read latency) between two requesters.
  - Port 0: CPU load/store path.
  - Port 1: DMA/debug loader.
- Sits between the CPU datapath and the data memory.
- Round-robin arbitration, req/gnt handshake, an optional lock for atomic read-modify-write sequences, and out-of-range address protection.

---
 rtl/dm_port_arbiter_pkg.sv | 20 ++
 rtl/dm_arb_rr_pick.sv | 35 +++
 rtl/dm_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// dm_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter: FSM state encoding,
//   port count and a small one-hot helper used by the arbiter and its picker.
package dm_port_arbiter_pkg;

    localparam logic DM_ARB_ARB    = 1'b0;
    localparam logic DM_ARB_LOCKED = 1'b1;
    localparam int   DM_ARB_PORTS  = 2;

    typedef enum logic {
        ST_ARB    = DM_ARB_ARB,
        ST_LOCKED = DM_ARB_LOCKED
    } dm_arb_state_e;

    // Port index -> one-hot port vector.
    function automatic logic [DM_ARB_PORTS-1:0] port_onehot(input logic idx);
        port_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arb_rr_pick.sv
// dm_arb_rr_pick
//   Combinational grant selection for the two-port data-memory arbiter.
//   Ports:
//     req     in   per-port request
//     rr_ptr  in   port favoured when both request (ARB state only)
//     state   in   arbiter FSM state
//     owner   in   lock owner (LOCKED state only)
//     gnt     out  one-hot grant, 0 when nobody is granted
//     gnt_idx out  index of the selected port (meaningful when gnt != 0)
module dm_arb_rr_pick
    import dm_port_arbiter_pkg::*;
(
    input  logic          [1:0] req,
    input  logic                rr_ptr,
    input  dm_arb_state_e       state,
    input  logic                owner,
    output logic          [1:0] gnt,
    output logic                gnt_idx
);

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
        if (state == ST_LOCKED) begin
            // Only the owner may be served; the other port simply waits.
            gnt_idx = owner;
            if (req[owner]) gnt = port_onehot(owner);
        end else begin
            // Single requester: req[1] is its index. Both: follow rr_ptr.
            gnt_idx = (req == 2'b11) ? rr_ptr : req[1];
            if (|req) gnt = port_onehot(gnt_idx);
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares a single-port synchronous-read data memory between the CPU
//   load/store path (port 0) and a DMA/debug loader (port 1). Round-robin
//   arbitration, optional lock for read-modify-write, out-of-range guard.
//
//   Handshake: a requester holds req/we/addr/wdata stable until it sees gnt.
//   gnt is combinational and high exactly in the cycle the memory command
//   issues; dropping req before gnt withdraws the request. A read granted in
//   cycle N answers with rvalid[g] in cycle N+1; writes answer with nothing
//   except addr_err when out of range.
//
//   Ports:
//     clk, rst (async, active low)
//     req, we, lock            per-port controls (bit i = port i)
//     addr, wdata              per-port buses, port i at [i*W +: W]
//     gnt                      one-hot grant
//     rvalid, rdata, addr_err  read response / range error (cycle N+1)
//     mem_rden, mem_wren, mem_addr, mem_wdata, mem_q   memory interface
//     dbg_state                current FSM state (0 = ARB, 1 = LOCKED)
//   Optional (DM_ARB_STATS_EN): grant_cnt0, grant_cnt1, conflict_cnt.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [1:0]            lock,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            addr_err,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [MEM_BITS-1:0]   mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_q,
    output logic                  dbg_state
`ifdef DM_ARB_STATS_EN
    ,
    output logic [31:0]           grant_cnt0,
    output logic [31:0]           grant_cnt1,
    output logic [31:0]           conflict_cnt
`endif
);

    dm_arb_state_e       state, state_nxt;
    logic                owner, owner_nxt;
    logic                rr_ptr;
    logic [1:0]          pick_gnt;
    logic                g;
    logic                gnt_any;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic                g_we;
    logic                in_range;
    logic                rd_pend;
    logic                rd_port;
    logic                rd_oor;
    logic [1:0]          err_q;

    dm_arb_rr_pick u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .state   (state),
        .owner   (owner),
        .gnt     (pick_gnt),
        .gnt_idx (g)
    );

    // Grants are forced off while reset is asserted so no command escapes.
    assign gnt     = rst ? pick_gnt : 2'b00;
    assign gnt_any = |gnt;

    assign g_addr   = g ? addr[ADDR_W +: ADDR_W]   : addr[0 +: ADDR_W];
    assign g_wdata  = g ? wdata[DATA_W +: DATA_W]  : wdata[0 +: DATA_W];
    assign g_we     = we[g];
    assign in_range = (g_addr[ADDR_W-1:MEM_BITS] == '0);

    assign mem_addr  = g_addr[MEM_BITS-1:0];
    assign mem_wdata = g_wdata;
    assign mem_wren  = gnt_any &  g_we & in_range;
    assign mem_rden  = gnt_any & ~g_we & in_range;

    // Lock is taken on a granted access with lock set, and released at the
    // end of any cycle where the owner's lock is low (granted or not).
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ST_ARB: begin
                if (gnt_any && lock[g]) begin
                    state_nxt = ST_LOCKED;
                    owner_nxt = g;
                end
            end
            ST_LOCKED: begin
                if (!lock[owner]) state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_ARB;
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
            rd_oor  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            // Fairness pointer only moves on grants made in ARB.
            if (state == ST_ARB && gnt_any) rr_ptr <= ~g;
            rd_pend <= gnt_any & ~g_we;
            rd_port <= g;
            rd_oor  <= ~in_range;
            err_q   <= (gnt_any && !in_range) ? port_onehot(g) : 2'b00;
        end
    end

    assign rvalid    = rd_pend ? port_onehot(rd_port) : 2'b00;
    // Out-of-range reads complete with zero data; mem_q is not touched.
    assign rdata     = (rd_pend && !rd_oor) ? mem_q : '0;
    assign addr_err  = err_q;
    assign dbg_state = state;

`ifdef DM_ARB_STATS_EN
    logic conflict;

    // A waiting request counts when the other port holds the grant or lock.
    always_comb begin
        conflict = (req[0] & ~gnt[0] & (gnt[1] | ((state == ST_LOCKED) &  owner)))
                 | (req[1] & ~gnt[1] & (gnt[0] | ((state == ST_LOCKED) & ~owner)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt[0])   grant_cnt0   <= grant_cnt0 + 32'd1;
            if (gnt[1])   grant_cnt1   <= grant_cnt1 + 32'd1;
            if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
